uart_transmitter: RTL

- Serialises parallel bytes onto a UART line: idle-high, one start bit (low), DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits (high).
- Counterpart of the team's uart_receiver, same symbol timing (CYCLES_PER_SYMBOL clocks per bit); sits between a byte source (ready/valid) and the board TX pin.
- Supports back-to-back frames with no idle gap, so benches can loop it directly into the receiver.

---
 rtl/uart_transmitter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/uart_transmitter.sv
// UART serialiser: start bit, DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits.
// The source hands bytes over with a ready/valid handshake. Back-to-back frames follow with no idle gap.
module uart_transmitter #(
  parameter int CYCLES_PER_SYMBOL = 125_000_000 / 115_200,
  parameter int DATA_BITS         = 8,
  parameter int STOP_BITS         = 1,
  parameter int PARITY            = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic                 signal_out,
  output logic                 busy
);
  localparam int SYM_W    = $clog2(CYCLES_PER_SYMBOL) + 1;
  localparam int MAX_BITS = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int BIT_W    = $clog2(MAX_BITS) + 1;

  localparam logic [SYM_W-1:0] SYM_LAST  = SYM_W'(CYCLES_PER_SYMBOL - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [SYM_W-1:0]     sym_cnt_q, sym_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 signal_out_q, signal_out_d;
  logic                 busy_q, busy_d;
  logic                 sym_end, last_stop, xfer, par_calc;

  assign par_calc = (PARITY == 1) ? ~(^data_in) : ^data_in;

  always_comb begin
    state_d   = state_q;
    sym_cnt_d = sym_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;

    sym_end    = (sym_cnt_q == SYM_LAST);
    last_stop  = (state_q == S_STOP) && sym_end && (bit_cnt_q == STOP_LAST);
    data_ready = !rst && ((state_q == S_IDLE) || last_stop);
    xfer       = data_valid && data_ready;

    if (state_q != S_IDLE)
      sym_cnt_d = sym_end ? '0 : sym_cnt_q + SYM_W'(1);

    case (state_q)
      S_IDLE: ;
      S_START:
        if (sym_end) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      S_DATA:
        if (sym_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      S_PARITY:
        if (sym_end) begin
          state_d   = S_STOP;
          bit_cnt_d = '0;
        end
      S_STOP:
        if (sym_end) begin
          if (bit_cnt_q == STOP_LAST) begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      default: state_d = S_IDLE;
    endcase

    // A transfer wins over the STOP->IDLE exit so the next start bit follows with no gap.
    if (xfer) begin
      state_d   = S_START;
      sym_cnt_d = '0;
      bit_cnt_d = '0;
      shift_d   = data_in;
      par_d     = par_calc;
    end

    // The line level is decoded from the next state so the pin is driven straight from a flop.
    case (state_d)
      S_START:  signal_out_d = 1'b0;
      S_DATA:   signal_out_d = shift_d[0];
      S_PARITY: signal_out_d = par_d;
      default:  signal_out_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sym_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      signal_out_q <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sym_cnt_q    <= sym_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      signal_out_q <= signal_out_d;
      busy_q       <= busy_d;
    end
  end

  assign signal_out = signal_out_q;
  assign busy       = busy_q;
endmodule
